// File: rtl/array_allocator.sv
// array_allocator: arbitrated owner of the array-number resource.
// Array numbers come from a bump counter of never-used arrays and from a LIFO
// stack of freed arrays. NReq requesters share the resource round-robin.
// Each operation takes three cycles: IDLE (arbitrate) -> EXEC -> HOLD.
// A successful alloc also pulses clearEn so arraySizes[clearIndex] starts empty.
//
// Optional feature macro: ARRAY_DOUBLE_FREE_CHECK_EN
//   defined   : an NArrays-bit in-use bitmap refuses a free of an unused array.
//   undefined : only the range and stack-full checks apply.
//
// Ports:
//   clock, reset           single clock; synchronous active-high reset
//   allocReq[NReq]         level request for a new array
//   freeReq[NReq]          level request to free freeArray slice i
//   freeArray[NReq*MEW]    array number to free, slice i per requester
//   ack[NReq]              one-cycle completion pulse to the winner
//   err                    operation refused (valid with ack)
//   array                  allocated number (valid with ack on alloc, no err)
//   clearEn, clearIndex    one-cycle clear strobe for the new array
//   allocs                 bump counter (arrays ever handed out fresh)
//   inUse                  allocs minus freed-stack depth
module array_allocator #(
  parameter int MemoryElementWidth = 12,
  parameter int NArrays            = 2000,
  parameter int NReq               = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NReq-1:0]                    allocReq,
  input  logic [NReq-1:0]                    freeReq,
  input  logic [NReq*MemoryElementWidth-1:0] freeArray,
  output logic [NReq-1:0]                    ack,
  output logic                               err,
  output logic [MemoryElementWidth-1:0]      array,
  output logic                               clearEn,
  output logic [MemoryElementWidth-1:0]      clearIndex,
  output logic [MemoryElementWidth:0]        allocs,
  output logic [MemoryElementWidth:0]        inUse
);
  localparam int MW = MemoryElementWidth;
  localparam int CW = MW + 1;
  localparam int IW = (NReq > 1) ? $clog2(NReq) : 1;
  localparam int AW = (NArrays > 1) ? $clog2(NArrays) : 1;
  localparam logic [CW-1:0] NA_C = CW'(NArrays);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, win_q;
  logic            free_q;
  logic [MW-1:0]   idx_q;
  logic [CW-1:0]   allocs_q, top_q;
  logic [NReq-1:0] ack_q;
  logic            err_q, clr_q;
  logic [MW-1:0]   array_q, clr_idx_q;
  logic [MW-1:0]   stack_q [NArrays];
`ifdef ARRAY_DOUBLE_FREE_CHECK_EN
  logic [NArrays-1:0] used_q;
`endif

  // Round-robin pick: search starts one past the last winner.
  logic [NReq-1:0] req;
  logic [IW-1:0]   pick;
  logic            found;
  int              cand;
  always_comb begin
    req   = allocReq | freeReq;
    pick  = last_q;
    found = 1'b0;
    cand  = 0;
    for (int off = 1; off <= NReq; off++) begin
      cand = (int'(last_q) + off) % NReq;
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = IW'(cand);
      end
    end
  end

  // EXEC decisions, evaluated from the latched op.
  logic [MW-1:0] stk_top, new_arr;
  logic          do_pop, do_bump, free_bad;
  always_comb begin
    stk_top  = stack_q[AW'(top_q - CW'(1))];
    do_pop   = !free_q && (top_q != '0);
    do_bump  = !free_q && (top_q == '0) && (allocs_q < NA_C);
    new_arr  = do_pop ? stk_top : allocs_q[MW-1:0];
    free_bad = ({1'b0, idx_q} >= allocs_q) || (top_q == NA_C);
`ifdef ARRAY_DOUBLE_FREE_CHECK_EN
    // Range check above already keeps idx_q below NArrays when it matters.
    if (!free_bad && !used_q[AW'(idx_q)]) free_bad = 1'b1;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found) state_d = S_EXEC;
      S_EXEC:  state_d = S_HOLD;
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      last_q    <= IW'(NReq - 1);
      win_q     <= '0;
      free_q    <= 1'b0;
      idx_q     <= '0;
      allocs_q  <= '0;
      top_q     <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      clr_q     <= 1'b0;
      array_q   <= '0;
      clr_idx_q <= '0;
`ifdef ARRAY_DOUBLE_FREE_CHECK_EN
      used_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      // Pulses default low; only EXEC raises them, so HOLD clears them.
      ack_q   <= '0;
      err_q   <= 1'b0;
      clr_q   <= 1'b0;
      case (state_q)
        S_IDLE: if (found) begin
          win_q  <= pick;
          free_q <= freeReq[pick];  // free wins when both are asserted
          idx_q  <= freeArray[int'(pick)*MW +: MW];
        end
        S_EXEC: begin
          ack_q  <= NReq'(1) << win_q;
          last_q <= win_q;
          if (free_q) begin
            if (free_bad) err_q <= 1'b1;
            else begin
              top_q <= top_q + CW'(1);
`ifdef ARRAY_DOUBLE_FREE_CHECK_EN
              used_q[AW'(idx_q)] <= 1'b0;
`endif
            end
          end else if (do_pop || do_bump) begin
            array_q   <= new_arr;
            clr_q     <= 1'b1;
            clr_idx_q <= new_arr;
            if (do_pop) top_q    <= top_q - CW'(1);
            else        allocs_q <= allocs_q + CW'(1);
`ifdef ARRAY_DOUBLE_FREE_CHECK_EN
            used_q[AW'(new_arr)] <= 1'b1;
`endif
          end else begin
            err_q <= 1'b1;  // exhausted
          end
        end
        default: ;
      endcase
    end
  end

  // Stack storage has no reset so it can map to block RAM.
  always_ff @(posedge clock) begin
    if (!reset && state_q == S_EXEC && free_q && !free_bad)
      stack_q[AW'(top_q)] <= idx_q;
  end

  assign ack        = ack_q;
  assign err        = err_q;
  assign array      = array_q;
  assign clearEn    = clr_q;
  assign clearIndex = clr_idx_q;
  assign allocs     = allocs_q;
  assign inUse      = allocs_q - top_q;
endmodule

// File: tb/tb_array_allocator.sv
module tb_array_allocator;
  localparam int MW = 4;
  localparam int NA = 4;
  localparam int NR = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic [NR-1:0]    allocReq, freeReq;
  logic [NR*MW-1:0] freeArray;
  logic [NR-1:0]    ack;
  logic             err, clearEn;
  logic [MW-1:0]    array, clearIndex;
  logic [MW:0]      allocs, inUse;

  array_allocator #(.MemoryElementWidth(MW), .NArrays(NA), .NReq(NR)) dut (
    .clock(clock), .reset(reset), .allocReq(allocReq), .freeReq(freeReq),
    .freeArray(freeArray), .ack(ack), .err(err), .array(array),
    .clearEn(clearEn), .clearIndex(clearIndex), .allocs(allocs), .inUse(inUse));

  always #5 clock = ~clock;

  typedef struct {
    logic [NR-1:0] ack;
    logic          err;
    logic          chk_arr;
    logic [MW-1:0] arr;
    logic          clr;
    logic [MW:0]   allocs;
    logic [MW:0]   inuse;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_op(input logic [NR-1:0] a, input logic e, input logic ca,
                           input int arr, input logic c, input int al, input int iu);
    exp_t x;
    x.ack = a; x.err = e; x.chk_arr = ca; x.arr = MW'(arr); x.clr = c;
    x.allocs = (MW+1)'(al); x.inuse = (MW+1)'(iu);
    exp_q.push_back(x);
  endtask

  // Monitor: pops one expectation per ack pulse.
  always @(negedge clock) begin
    if (!reset) begin
      if (clearEn && ack == '0) begin
        errors++;
        $display("FAIL clear_without_ack: clearEn=%0b ack=%b required clearEn=0", clearEn, ack);
      end
      if (ack != '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: ack=%b required no ack", ack);
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          if (ack !== x.ack || err !== x.err || clearEn !== x.clr ||
              (x.chk_arr && array !== x.arr) || (x.clr && clearIndex !== x.arr) ||
              allocs !== x.allocs || inUse !== x.inuse) begin
            errors++;
            $display("FAIL op: got ack=%b err=%0b arr=%0d clr=%0b cidx=%0d allocs=%0d inUse=%0d required ack=%b err=%0b arr=%0d clr=%0b allocs=%0d inUse=%0d",
                     ack, err, array, clearEn, clearIndex, allocs, inUse,
                     x.ack, x.err, x.arr, x.clr, x.allocs, x.inuse);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // One request held for exactly one IDLE sample, then wait out EXEC and HOLD.
  task automatic op(input int port, input bit a, input bit f, input int idx);
    @(negedge clock);
    allocReq[port] = a;
    freeReq[port]  = f;
    freeArray[port*MW +: MW] = MW'(idx);
    @(posedge clock); #1;
    allocReq = '0; freeReq = '0;
    repeat (2) @(posedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; allocReq = '0; freeReq = '0;
    repeat (2) @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; allocReq = '0; freeReq = '0; freeArray = '0;
    repeat (2) @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_ack", int'(ack), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_clearEn", int'(clearEn), 0);
    chk("rst_array", int'(array), 0);
    chk("rst_clearIndex", int'(clearIndex), 0);
    chk("rst_allocs", int'(allocs), 0);
    chk("rst_inUse", int'(inUse), 0);

    // Fresh allocs
    expect_op(2'b01, 0, 1, 0, 1, 1, 1); op(0, 1, 0, 0);
    expect_op(2'b01, 0, 1, 1, 1, 2, 2); op(0, 1, 0, 0);
    expect_op(2'b10, 0, 1, 2, 1, 3, 3); op(1, 1, 0, 0);
    // LIFO reuse: free 1 then 0, realloc gives 0 then 1
    expect_op(2'b01, 0, 0, 0, 0, 3, 2); op(0, 0, 1, 1);
    expect_op(2'b01, 0, 0, 0, 0, 3, 1); op(0, 0, 1, 0);
    expect_op(2'b01, 0, 1, 0, 1, 3, 2); op(0, 1, 0, 0);
    expect_op(2'b01, 0, 1, 1, 1, 3, 3); op(0, 1, 0, 0);
    // Bump resumes, then exhaustion, then bad free
    expect_op(2'b01, 0, 1, 3, 1, 4, 4); op(0, 1, 0, 0);
    expect_op(2'b01, 1, 0, 0, 0, 4, 4); op(0, 1, 0, 0);
    expect_op(2'b01, 1, 0, 0, 0, 4, 4); op(0, 0, 1, 7);
    // Free priority: alloc+free of 2 together frees; next alloc returns 2
    expect_op(2'b01, 0, 0, 0, 0, 4, 3); op(0, 1, 1, 2);
    expect_op(2'b01, 0, 1, 2, 1, 4, 4); op(0, 1, 0, 0);

    // Reset while in EXEC: no ack, counters cleared
    @(negedge clock);
    allocReq[0] = 1'b1;
    @(posedge clock); #1;
    allocReq = '0; reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("exec_reset_allocs", int'(allocs), 0);
    chk("exec_reset_inUse", int'(inUse), 0);
    repeat (3) @(posedge clock);
    expect_op(2'b01, 0, 1, 0, 1, 1, 1); op(0, 1, 0, 0);

    // Double free of 1
    expect_op(2'b01, 0, 1, 1, 1, 2, 2); op(0, 1, 0, 0);
    expect_op(2'b01, 0, 0, 0, 0, 2, 1); op(0, 0, 1, 1);
`ifdef ARRAY_DOUBLE_FREE_CHECK_EN
    expect_op(2'b01, 1, 0, 0, 0, 2, 1); op(0, 0, 1, 1);
    expect_op(2'b01, 0, 1, 1, 1, 2, 2); op(0, 1, 0, 0);
    expect_op(2'b01, 0, 1, 2, 1, 3, 3); op(0, 1, 0, 0);
`else
    expect_op(2'b01, 0, 0, 0, 0, 2, 0); op(0, 0, 1, 1);
    expect_op(2'b01, 0, 1, 1, 1, 2, 1); op(0, 1, 0, 0);
    expect_op(2'b01, 0, 1, 1, 1, 2, 2); op(0, 1, 0, 0);
`endif

    // Round-robin: both ports hold allocReq for four operations
    do_reset();
    expect_op(2'b01, 0, 1, 0, 1, 1, 1);
    expect_op(2'b10, 0, 1, 1, 1, 2, 2);
    expect_op(2'b01, 0, 1, 2, 1, 3, 3);
    expect_op(2'b10, 0, 1, 3, 1, 4, 4);
    @(negedge clock);
    allocReq = 2'b11;
    repeat (10) @(posedge clock); #1;
    allocReq = '0;
    repeat (4) @(posedge clock);
    @(negedge clock);

    chk("pending_expectations", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
